multi_timer: RTL and testbench
==============================

MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent timer channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 32, counter/interval width per channel (2..64).
REQ-003 SHALL have parameter PRE_W, default 16, prescaler width.
REQ-004 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port prescale  input  PRE_W  shared divider; strobe period = prescale+1 clk cycles.
REQ-007 SHALL have port start  input  NCH  per-channel pulse; load and (re)start channel.
REQ-008 SHALL have port stop  input  NCH  per-channel pulse; halt channel.
REQ-009 SHALL have port oneshot  input  NCH  per-channel mode; 1 = one-shot, 0 = periodic; sampled on start.
REQ-010 SHALL have port interval  input  NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]; sampled on start.
REQ-011 SHALL have port tick  output  NCH  registered one-cycle terminal-count pulse per channel.
REQ-012 SHALL have port busy  output  NCH  channel in RUN state.
REQ-013 SHALL have port count  output  NCH*WIDTH  live counter value per channel, same packing as interval.

Function
REQ-014 Prescaler: free-running counter pre_cnt; strobe = (pre_cnt >= prescale); on strobe pre_cnt<=0, else pre_cnt+1; prescale=0 gives strobe every cycle; a prescale decrease below pre_cnt wraps on the next edge.
REQ-015 Each channel SHALL have states IDLE and RUN; busy = (state==RUN).
REQ-016 start[i] (either state) SHALL latch interval_i and oneshot_i, clear counter to 0, enter RUN; no counting occurs on the start edge.
REQ-017 In RUN on strobe: if counter == latched interval, tick<=1, counter<=0, and if one-shot state<=IDLE; else counter<=counter+1, tick<=0.
REQ-018 tick SHALL be 0 on every edge not covered by REQ-017's terminal case; pulse width exactly one clk per terminal event.
REQ-019 Period SHALL be (interval+1) strobes; interval=0 periodic with prescale=0 holds tick continuously high.
REQ-020 Counter SHALL never exceed latched interval; no overflow path; interval input changes while RUN are ignored.
REQ-021 stop[i] SHALL force IDLE, hold counter value (not cleared), suppress tick on that edge.
REQ-022 start and stop asserted same cycle: stop wins, channel IDLE, counter unchanged.
REQ-023 stop coincident with terminal strobe: stop wins, no tick.
REQ-024 In IDLE, counter holds and tick=0 regardless of strobe.
REQ-025 One-shot terminal: tick rises and busy falls on the same edge.
REQ-026 Channels SHALL be fully independent apart from the shared strobe.

Reset
REQ-027 reset=1 SHALL asynchronously clear pre_cnt, all counters, latched intervals/modes, tick, busy to 0, state IDLE.
REQ-028 Reset deassertion SHALL take effect on the next posedge; start asserted on that edge SHALL be honoured.

Structure
REQ-029 Shared package SHALL hold state encoding (ST_IDLE, ST_RUN) and mode constants (MODE_PERIODIC=0, MODE_ONESHOT=1).
REQ-030 Per-channel logic SHALL be a sub-module timer_channel (params WIDTH), instantiated NCH times by generate; prescaler stays in multi_timer.

Verification (NCH=4, WIDTH=8, PRE_W=4)
REQ-031 Assert reset mid-cycle with channels running -> tick, busy, count all 0 immediately, before next edge.
REQ-032 prescale=0, ch0 periodic interval=3, start pulse at edge T -> tick high after edges T+4, T+8, T+12; count sequence 1,2,3,0.
REQ-033 prescale=2, ch1 one-shot interval=5 -> exactly one tick 16..18 clk after start; busy falls on that edge; no further ticks over 100 clk.
REQ-034 ch2 periodic interval=9, prescale=0, stop when count=2 -> count holds 2, busy 0, no tick; later start -> count 0 then 1.
REQ-035 start and stop same cycle on idle ch3 -> busy stays 0; ch0 interval=0 periodic prescale=0 -> tick[0] constantly 1 after first edge.
REQ-036 All four channels started same edge with intervals 1,2,3,4 -> independent tick periods 2,3,4,5 clk.

Source files
------------

// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: shared channel state encoding and mode constants.
package multi_timer_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one interval timer counting shared strobes, periodic or one-shot.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             oneshot_i,
  input  logic [WIDTH-1:0] interval_i,
  output logic             tick_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] count_o
);
  state_e           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] ivl_q;
  logic             mode_q;
  logic             tick_q;
  // stop outranks start and the terminal strobe; the counter is held on stop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ivl_q   <= '0;
      mode_q  <= MODE_PERIODIC;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (stop_i) begin
        state_q <= ST_IDLE;
      end else if (start_i) begin
        ivl_q   <= interval_i;
        mode_q  <= oneshot_i;
        cnt_q   <= '0;
        state_q <= ST_RUN;
      end else if (state_q == ST_RUN && strobe_i) begin
        if (cnt_q == ivl_q) begin
          tick_q <= 1'b1;
          cnt_q  <= '0;
          if (mode_q == MODE_ONESHOT) state_q <= ST_IDLE;
        end else begin
          cnt_q <= cnt_q + WIDTH'(1);
        end
      end
    end
  end
  assign tick_o  = tick_q;
  assign busy_o  = (state_q == ST_RUN);
  assign count_o = cnt_q;
endmodule

// File: rtl/multi_timer.sv
// multi_timer: shared prescaler strobe driving NCH independent timer channels.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int PRE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PRE_W-1:0]   prescale,
  input  logic [NCH-1:0]     start,
  input  logic [NCH-1:0]     stop,
  input  logic [NCH-1:0]     oneshot,
  input  logic [NCH*WIDTH-1:0] interval,
  output logic [NCH-1:0]     tick,
  output logic [NCH-1:0]     busy,
  output logic [NCH*WIDTH-1:0] count
);
  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;
  logic             strobe;
  // >= rather than == so a prescale drop below pre_cnt wraps at once
  always_comb begin
    strobe    = (pre_cnt_q >= prescale);
    pre_cnt_d = strobe ? '0 : pre_cnt_q + PRE_W'(1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre_cnt_q <= '0;
    else       pre_cnt_q <= pre_cnt_d;
  end
  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      timer_channel #(.WIDTH(WIDTH)) u_ch (
        .clk       (clk),
        .reset     (reset),
        .strobe_i  (strobe),
        .start_i   (start[i]),
        .stop_i    (stop[i]),
        .oneshot_i (oneshot[i]),
        .interval_i(interval[i*WIDTH +: WIDTH]),
        .tick_o    (tick[i]),
        .busy_o    (busy[i]),
        .count_o   (count[i*WIDTH +: WIDTH])
      );
    end
  endgenerate
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: vector table, directed corner sequences and a random run against a strobe-counting model.
module tb_multi_timer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  prescale = '0;
  logic [3:0]  start = '0;
  logic [3:0]  stop = '0;
  logic [3:0]  oneshot = '0;
  logic [31:0] interval = '0;
  logic [3:0]  tick;
  logic [3:0]  busy;
  logic [31:0] count;

  int total = 0;
  int bad = 0;

  multi_timer #(.NCH(4), .WIDTH(8), .PRE_W(4)) dut (
    .clk(clk), .reset(reset), .prescale(prescale), .start(start), .stop(stop),
    .oneshot(oneshot), .interval(interval), .tick(tick), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [3:0]  sp;
    logic [31:0] ivl;
    logic [3:0]  et;
    logic [3:0]  eb;
    logic [31:0] ec;
  } vec_t;

  function automatic logic [31:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = '0; stop = '0; oneshot = '0; interval = '0; prescale = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t tbl [9];
  int   m_n [4];
  int   m_ivl [4];
  bit   m_run [4];
  bit   m_os [4];
  logic [3:0]  m_tick;
  logic [31:0] m_cnt;
  int   m_s;
  bit   strobe;
  int   found, lat, extra, ones;
  logic [3:0] exp_t;

  initial begin
    tbl[0] = '{4'b0101, 4'b0000, pk(3,0,9,0), 4'b0000, 4'b0101, pk(0,0,0,0)};
    tbl[1] = '{4'b0000, 4'b0000, pk(3,0,9,0), 4'b0000, 4'b0101, pk(1,0,1,0)};
    tbl[2] = '{4'b0000, 4'b0000, pk(3,0,9,0), 4'b0000, 4'b0101, pk(2,0,2,0)};
    tbl[3] = '{4'b0000, 4'b0100, pk(3,0,9,0), 4'b0000, 4'b0001, pk(3,0,2,0)};
    tbl[4] = '{4'b1000, 4'b1000, pk(3,0,9,0), 4'b0001, 4'b0001, pk(0,0,2,0)};
    tbl[5] = '{4'b0000, 4'b0000, pk(3,0,9,0), 4'b0000, 4'b0001, pk(1,0,2,0)};
    tbl[6] = '{4'b0100, 4'b0000, pk(3,0,9,0), 4'b0000, 4'b0101, pk(2,0,0,0)};
    tbl[7] = '{4'b0000, 4'b0000, pk(3,0,9,0), 4'b0000, 4'b0101, pk(3,0,1,0)};
    tbl[8] = '{4'b0000, 4'b0000, pk(3,0,9,0), 4'b0001, 4'b0101, pk(0,0,2,0)};

    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_tick", {28'd0, tick}, 32'd0);
    chk("rst_busy", {28'd0, busy}, 32'd0);
    chk("rst_count", count, 32'd0);
    reset = 1'b0;

    for (int r = 0; r < 9; r++) begin
      start = tbl[r].st; stop = tbl[r].sp; interval = tbl[r].ivl;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_tick", r), {28'd0, tick}, {28'd0, tbl[r].et});
      chk($sformatf("vec%0d_busy", r), {28'd0, busy}, {28'd0, tbl[r].eb});
      chk($sformatf("vec%0d_count", r), count, tbl[r].ec);
      @(negedge clk);
    end
    start = '0; stop = '0;

    do_reset();
    prescale = 4'd2; oneshot = 4'b0010; interval = pk(0,5,0,0); start = 4'b0010;
    @(posedge clk); #1 start = '0;
    found = 0; lat = 0;
    for (int k = 1; k <= 40 && found == 0; k++) begin
      @(posedge clk); #1;
      if (tick[1]) begin
        found = 1; lat = k;
        chk("os_busy_fall", {31'd0, busy[1]}, 32'd0);
      end
    end
    chk("os_tick_seen", found, 1);
    chk("os_latency_16_18", (lat >= 16 && lat <= 18) ? 32'd1 : 32'd0, 32'd1);
    extra = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (tick[1]) extra++;
    end
    chk("os_no_retick", extra, 0);

    do_reset();
    interval = '0; start = 4'b0001;
    @(posedge clk); #1 start = '0;
    ones = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (tick[0]) ones++;
    end
    chk("ivl0_tick_high", ones, 10);
    chk("ivl0_busy", {31'd0, busy[0]}, 32'd1);

    do_reset();
    interval = pk(1,2,3,4); start = 4'b1111;
    @(posedge clk); #1 start = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) exp_t[i] = (n % (i + 2) == 0);
      chk($sformatf("indep_tick_n%0d", n), {28'd0, tick}, {28'd0, exp_t});
    end

    @(negedge clk); #2 reset = 1'b1;
    #1;
    chk("async_rst_tick", {28'd0, tick}, 32'd0);
    chk("async_rst_busy", {28'd0, busy}, 32'd0);
    chk("async_rst_count", count, 32'd0);
    @(negedge clk) reset = 1'b0;

    do_reset();
    m_s = 0;
    for (int i = 0; i < 4; i++) begin m_n[i] = 0; m_ivl[i] = 0; m_run[i] = 0; m_os[i] = 0; end
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 49) == 0) prescale = 4'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) begin
        start[i] = ($urandom_range(0, 19) == 0);
        stop[i]  = ($urandom_range(0, 39) == 0);
      end
      oneshot  = 4'($urandom);
      interval = $urandom & 32'h0707_0707;
      @(posedge clk);
      strobe = (m_s >= int'(prescale));
      m_s = strobe ? 0 : m_s + 1;
      for (int i = 0; i < 4; i++) begin
        m_tick[i] = 1'b0;
        if (stop[i]) m_run[i] = 0;
        else if (start[i]) begin
          m_run[i] = 1; m_n[i] = 0; m_ivl[i] = int'(interval[i*8 +: 8]); m_os[i] = oneshot[i];
        end else if (m_run[i] && strobe) begin
          m_n[i]++;
          if (m_n[i] % (m_ivl[i] + 1) == 0) begin
            m_tick[i] = 1'b1;
            if (m_os[i]) m_run[i] = 0;
          end
        end
      end
      m_cnt = pk(m_n[0] % (m_ivl[0] + 1), m_n[1] % (m_ivl[1] + 1),
                 m_n[2] % (m_ivl[2] + 1), m_n[3] % (m_ivl[3] + 1));
      #1;
      chk($sformatf("rnd%0d_tick", c), {28'd0, tick}, {28'd0, m_tick});
      chk($sformatf("rnd%0d_busy", c), {28'd0, busy},
          {28'd0, m_run[3], m_run[2], m_run[1], m_run[0]});
      chk($sformatf("rnd%0d_count", c), count, m_cnt);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
